// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - bin through one full-subtractor cell, LSB first.
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic br, ai, bi, d, br_nx, last;
  assign ai = ra[cnt];
  assign bi = rb[cnt];
  assign d = ai ^ bi ^ br;
  assign br_nx = (~ai & bi) | (~(ai ^ bi) & br);
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = in_valid ? RUN : IDLE;
    else if (state == RUN) state_nx = last ? DONE : RUN;
    else if (state == DONE) state_nx = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= b;
      br <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      diff <= {d, diff[WIDTH-1:1]};
      br <= br_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        bout <= br_nx;
        ovf <= (ra[WIDTH-1] != rb[WIDTH-1]) && (d != ra[WIDTH-1]);
      end
    end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: directed and randomised checks of the serial subtractor against a queued reference.
module tb_serial_ripple_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, bin = 1'b0;
  logic out_valid, out_ready = 1'b0, bout, ovf;
  logic [W-1:0] a = '0, b = '0, diff;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic bo; logic ov; logic [W-1:0] d;} exp_t;
  exp_t sb[$];

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       input int hold, input bit noise);
    exp_t e, got;
    int lat;
    e.d = xa - xb - {{(W-1){1'b0}}, xbin};
    e.bo = int'(xa) < int'(xb) + int'(xbin);
    e.ov = (xa[W-1] != xb[W-1]) && (e.d[W-1] != xa[W-1]);
    out_ready = hold == 0;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_run", {31'b0, in_ready}, 0);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (noise) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); in_valid = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, W);
    got = sb.size() > 0 ? sb.pop_front() : '0;
    chk("diff", {24'b0, diff}, {24'b0, got.d});
    chk("bout", {31'b0, bout}, {31'b0, got.bo});
    chk("ovf", {31'b0, ovf}, {31'b0, got.ov});
    for (int i = 0; i < hold; i++) begin
      in_valid = i == 2;
      a = ~xa;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_result", {22'b0, bout, ovf, diff}, {22'b0, got});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", {30'b0, in_ready, out_valid}, 2);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", {22'b0, bout, ovf, diff}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
    do_op(8'hC3, 8'h5A, 1'b1, 5, 1'b0);
    // abandon an operation mid-flight with an asynchronous reset
    a = 8'h55; b = 8'h0A; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_result", {22'b0, bout, ovf, diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_abandoned_valid", seen, 0);
    do_op(8'h10, 8'h01, 1'b0, 0, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1);
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
